// File: rtl/readout_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | readout_pkg: shared FSM encoding and lane constants for the readout  |
// | packer. Revision: 1.0                                                |
// +----------------------------------------------------------------------+
package readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  localparam int DIN_W_DEFAULT  = 16;
  localparam int DOUT_W_DEFAULT = 256;
  localparam int LANES          = DOUT_W_DEFAULT / DIN_W_DEFAULT;

  function automatic int lanes_of(input int dout_w, input int din_w);
    return dout_w / din_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lane_shift_reg: accumulates samples MSB-lane first into one packed   |
// | word; lanes not yet written read as zero. Revision: 1.0              |
// +----------------------------------------------------------------------+
module lane_shift_reg
  import readout_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEFAULT,
  parameter int DOUT_W = DOUT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DIN_W-1:0]  i_din,
  input  logic              i_emit,
  output logic [DOUT_W-1:0] o_word,
  output logic              o_lane_last
);

  localparam int c_lanes  = lanes_of(DOUT_W, DIN_W);
  localparam int c_lane_w = (c_lanes > 1) ? $clog2(c_lanes) : 1;

  logic [DOUT_W-1:0]   r_lanes;
  logic [c_lane_w-1:0] r_lane_cnt;
  logic [DOUT_W-1:0]   w_word;

  // Word as it will look once the current sample lands in its lane.
  genvar i;
  generate
    for (i = 0; i < c_lanes; i++) begin : g_lane
      assign w_word[DOUT_W-1-i*DIN_W -: DIN_W] =
        (i_load && (r_lane_cnt == c_lane_w'(i))) ? i_din
                                                 : r_lanes[DOUT_W-1-i*DIN_W -: DIN_W];
    end
  endgenerate

  assign o_word      = w_word;
  assign o_lane_last = (r_lane_cnt == c_lane_w'(c_lanes - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lanes    <= '0;
      r_lane_cnt <= '0;
    end else if (i_clear || (i_load && i_emit)) begin
      r_lanes    <= '0;
      r_lane_cnt <= '0;
    end else if (i_load) begin
      r_lanes    <= w_word;
      r_lane_cnt <= r_lane_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sensor_readout_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sensor_readout_packer: packs a frame of sensor samples into wide     |
// | words for a host-side FIFO. Revision: 1.0                            |
// +----------------------------------------------------------------------+
module sensor_readout_packer
  import readout_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEFAULT,
  parameter int DOUT_W = DOUT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Num_Pix,
  input  logic              capture_en,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_valid,
  output logic [DOUT_W-1:0] dout,
  output logic              wr_en,
  input  logic              almost_full,
  output logic              frame_done,
  output logic [31:0]       frame_cnt,
  output logic              overflow,
  output logic              busy
);

  state_t            r_state;
  logic [31:0]       r_num_pix;
  logic [31:0]       r_pix_cnt;
  logic [31:0]       r_frame_cnt;
  logic [DOUT_W-1:0] r_out_word;
  logic              r_out_valid;
  logic              r_overflow;

  logic [DOUT_W-1:0] w_word;
  logic              w_lane_last;
  logic              w_start;
  logic              w_take;
  logic [31:0]       w_pix_next;
  logic              w_final;
  logic              w_emit;
  logic              w_wr_en;
  logic              w_occupied;
  logic              w_frame_done;

  assign w_start    = (r_state == ST_IDLE) && capture_en && (Num_Pix != 32'd0);
  assign w_take     = (r_state == ST_CAPTURE) && din_valid;
  assign w_pix_next = r_pix_cnt + 32'd1;
  assign w_final    = w_take && (w_pix_next == r_num_pix);
  assign w_emit     = w_take && (w_lane_last || w_final);
  assign w_wr_en    = r_out_valid && !almost_full;
  // A register being written this cycle is free to accept the next word.
  assign w_occupied = r_out_valid && !w_wr_en;
  // In FLUSH the held word is the last one of the frame, even if the true
  // final word was dropped on overflow.
  assign w_frame_done = w_wr_en && (r_state == ST_FLUSH);

  lane_shift_reg #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W)
  ) u_lanes (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_start),
    .i_load      (w_take),
    .i_din       (din),
    .i_emit      (w_emit),
    .o_word      (w_word),
    .o_lane_last (w_lane_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_num_pix <= '0;
      r_pix_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_CAPTURE;
            r_num_pix <= Num_Pix;
            r_pix_cnt <= '0;
          end
        end
        ST_CAPTURE: begin
          if (w_take) begin
            r_pix_cnt <= w_pix_next;
            if (w_final) r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_wr_en) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_emit && !w_occupied) begin
        r_out_word  <= w_word;
        r_out_valid <= 1'b1;
      end else if (w_wr_en) begin
        r_out_valid <= 1'b0;
      end
      if (w_emit && w_occupied) r_overflow <= 1'b1;
      r_frame_cnt <= r_frame_cnt + {31'd0, w_frame_done};
    end
  end

  assign dout       = r_out_word;
  assign wr_en      = w_wr_en;
  assign frame_done = w_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign overflow   = r_overflow;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
